// File: rtl/slv_fsm_mux.sv
// Single-outstanding register-access router: one master request goes to one of N_SLV slaves.
// Optional slave-ack timeout is enabled by defining SLV_FSM_TIMEOUT_EN.
module slv_fsm_mux #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    N_SLV      = 4,
    parameter int                    TMO_WIDTH  = 8,
    parameter int                    TMO_CYCLES = 200,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mst__fsm__req_vld,
    input  logic                          mst__fsm__rd_en,
    input  logic                          mst__fsm__wr_en,
    input  logic [ADDR_WIDTH-1:0]         mst__fsm__addr,
    input  logic [DATA_WIDTH-1:0]         mst__fsm__wr_data,
    input  logic                          mst__fsm__sync_reset,
    input  logic [N_SLV-1:0]              mst__fsm__slv_sel,
    output logic                          fsm__mst__ack_vld,
    output logic                          fsm__mst__err,
    output logic [DATA_WIDTH-1:0]         fsm__mst__rd_data,
    output logic [N_SLV-1:0]              fsm__slv__req_vld,
    output logic [ADDR_WIDTH-1:0]         fsm__slv__addr,
    output logic [DATA_WIDTH-1:0]         fsm__slv__wr_data,
    output logic                          fsm__slv__wr_en,
    output logic                          fsm__slv__rd_en,
    output logic                          fsm__slv__sync_reset,
    input  logic [N_SLV-1:0]              slv__fsm__ack_vld,
    input  logic [N_SLV*DATA_WIDTH-1:0]   slv__fsm__rd_data,
    output logic                          cs_is_idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_ERR_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic [N_SLV-1:0]        sel_q, sel_d;
`ifdef SLV_FSM_TIMEOUT_EN
    logic [TMO_WIDTH-1:0]    cnt_q, cnt_d;
`endif

    logic                    ack_hit;
    logic [DATA_WIDTH-1:0]   sel_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            sel_q     <= '0;
`ifdef SLV_FSM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            sel_q     <= sel_d;
`ifdef SLV_FSM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Only acks from the latched slave count; sel_q is one-hot so OR-ing slices is a mux.
    always_comb begin
        ack_hit     = |(slv__fsm__ack_vld & sel_q);
        sel_rd_data = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rd_data = sel_rd_data | slv__fsm__rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        addr_d               = addr_q;
        wr_data_d            = wr_data_q;
        rd_en_d              = rd_en_q;
        wr_en_d              = wr_en_q;
        sel_d                = sel_q;
`ifdef SLV_FSM_TIMEOUT_EN
        cnt_d                = cnt_q;
`endif
        fsm__mst__ack_vld    = 1'b0;
        fsm__mst__err        = 1'b0;
        fsm__mst__rd_data    = '0;
        fsm__slv__req_vld    = '0;
        fsm__slv__addr       = '0;
        fsm__slv__wr_data    = '0;
        fsm__slv__wr_en      = 1'b0;
        fsm__slv__rd_en      = 1'b0;
        fsm__slv__sync_reset = mst__fsm__sync_reset;
        cs_is_idle           = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_is_idle = 1'b1;
                if (!mst__fsm__sync_reset && mst__fsm__req_vld) begin
                    if ($onehot(mst__fsm__slv_sel)) begin
                        addr_d    = mst__fsm__addr;
                        wr_data_d = mst__fsm__wr_data;
                        rd_en_d   = mst__fsm__rd_en;
                        wr_en_d   = mst__fsm__wr_en;
                        sel_d     = mst__fsm__slv_sel;
`ifdef SLV_FSM_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                        state_d   = S_WAIT_ACK;
                    end else begin
                        state_d = S_ERR_RESP;
                    end
                end
            end

            // A same-cycle slave ack is still forwarded even when an abort arrives.
            S_WAIT_ACK: begin
                fsm__slv__req_vld = sel_q;
                fsm__slv__addr    = addr_q;
                fsm__slv__wr_data = wr_data_q;
                fsm__slv__wr_en   = wr_en_q;
                fsm__slv__rd_en   = rd_en_q;
                if (ack_hit) begin
                    fsm__mst__ack_vld = 1'b1;
                    fsm__mst__rd_data = sel_rd_data;
                    state_d           = S_IDLE;
`ifdef SLV_FSM_TIMEOUT_EN
                end else if (!mst__fsm__sync_reset &&
                             cnt_q == TMO_WIDTH'(TMO_CYCLES - 1)) begin
                    fsm__mst__ack_vld = 1'b1;
                    fsm__mst__err     = 1'b1;
                    fsm__mst__rd_data = ERR_DATA;
                    state_d           = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
                if (mst__fsm__sync_reset) begin
                    state_d = S_IDLE;
                end
            end

            S_ERR_RESP: begin
                if (!mst__fsm__sync_reset) begin
                    fsm__mst__ack_vld = 1'b1;
                    fsm__mst__err     = 1'b1;
                    fsm__mst__rd_data = ERR_DATA;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_slv_fsm_mux.sv
// Bench for slv_fsm_mux: directed cases followed by random transactions against a transaction model.
// Timeout expectations follow SLV_FSM_TIMEOUT_EN when it is defined for the build.
module tb_slv_fsm_mux;

    localparam int          AW   = 64;
    localparam int          DW   = 32;
    localparam int          NS   = 4;
    localparam int          TMO  = 5;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic              clk;
    logic              rst;
    logic              mst_req_vld;
    logic              mst_rd_en;
    logic              mst_wr_en;
    logic [AW-1:0]     mst_addr;
    logic [DW-1:0]     mst_wr_data;
    logic              mst_sync_reset;
    logic [NS-1:0]     mst_slv_sel;
    logic              ack_vld;
    logic              err;
    logic [DW-1:0]     rd_data;
    logic [NS-1:0]     slv_req_vld;
    logic [AW-1:0]     slv_addr;
    logic [DW-1:0]     slv_wr_data;
    logic              slv_wr_en;
    logic              slv_rd_en;
    logic              slv_sync_reset;
    logic [NS-1:0]     slv_ack_vld;
    logic [NS*DW-1:0]  slv_rd_data;
    logic              cs_is_idle;

    int testsRun;
    int testsFailed;

    slv_fsm_mux #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_SLV      (NS),
        .TMO_WIDTH  (8),
        .TMO_CYCLES (TMO),
        .ERR_DATA   (ERRD)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mst__fsm__req_vld    (mst_req_vld),
        .mst__fsm__rd_en      (mst_rd_en),
        .mst__fsm__wr_en      (mst_wr_en),
        .mst__fsm__addr       (mst_addr),
        .mst__fsm__wr_data    (mst_wr_data),
        .mst__fsm__sync_reset (mst_sync_reset),
        .mst__fsm__slv_sel    (mst_slv_sel),
        .fsm__mst__ack_vld    (ack_vld),
        .fsm__mst__err        (err),
        .fsm__mst__rd_data    (rd_data),
        .fsm__slv__req_vld    (slv_req_vld),
        .fsm__slv__addr       (slv_addr),
        .fsm__slv__wr_data    (slv_wr_data),
        .fsm__slv__wr_en      (slv_wr_en),
        .fsm__slv__rd_en      (slv_rd_en),
        .fsm__slv__sync_reset (slv_sync_reset),
        .slv__fsm__ack_vld    (slv_ack_vld),
        .slv__fsm__rd_data    (slv_rd_data),
        .cs_is_idle           (cs_is_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Random data on every slave slice, with the chosen slave's slice forced to its answer.
    task automatic driveSlaveData(input logic [NS-1:0] sel, input logic [DW-1:0] value);
        for (int i = 0; i < NS; i++) begin
            slv_rd_data[i*DW +: DW] = sel[i] ? value : DW'($urandom);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_idle"},    64'(cs_is_idle),  64'd1);
        checkOutput({tag, "_ack"},     64'(ack_vld),     64'd0);
        checkOutput({tag, "_err"},     64'(err),         64'd0);
        checkOutput({tag, "_rdata"},   64'(rd_data),     64'd0);
        checkOutput({tag, "_sreq"},    64'(slv_req_vld), 64'd0);
        checkOutput({tag, "_saddr"},   64'(slv_addr),    64'd0);
        checkOutput({tag, "_swdata"},  64'(slv_wr_data), 64'd0);
        checkOutput({tag, "_swen"},    64'(slv_wr_en),   64'd0);
        checkOutput({tag, "_sren"},    64'(slv_rd_en),   64'd0);
    endtask

    // Idle cycle with a random (possibly late) slave ack that must not reach the master.
    task automatic idleCycle();
        @(posedge clk);
        #1;
        mst_req_vld    = 1'b0;
        mst_sync_reset = 1'b0;
        slv_ack_vld    = NS'($urandom);
        driveSlaveData('0, '0);
        #1;
        checkIdleOutputs("post");
        checkOutput("post_ssync", 64'(slv_sync_reset), 64'd0);
    endtask

    // One master transaction; expectations come from the end cycle implied by delay/abort/timeout.
    task automatic applyStimulus(input logic [NS-1:0] sel, input bit rd, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] rdval,
                                 input int delay, input int abortAt, input bit stray);
        bit            mapped;
        bit            tmo;
        int            endCycle;
        bit            expAck;
        bit            expErr;
        logic [DW-1:0] expData;

        mapped = (sel != '0) && ((sel & (sel - NS'(1))) == '0);

        @(posedge clk);
        #1;
        mst_req_vld    = 1'b1;
        mst_rd_en      = rd;
        mst_wr_en      = !rd;
        mst_addr       = addr;
        mst_wr_data    = wdata;
        mst_slv_sel    = sel;
        mst_sync_reset = 1'b0;
        slv_ack_vld    = NS'($urandom);
        driveSlaveData('0, '0);
        #1;
        checkOutput("acc_idle", 64'(cs_is_idle),  64'd1);
        checkOutput("acc_ack",  64'(ack_vld),     64'd0);
        checkOutput("acc_sreq", 64'(slv_req_vld), 64'd0);

        if (!mapped) begin
            @(posedge clk);
            #1;
            mst_req_vld = 1'b0;
            slv_ack_vld = NS'($urandom);
            driveSlaveData('0, '0);
            #1;
            checkOutput("err_ack",   64'(ack_vld),     64'd1);
            checkOutput("err_err",   64'(err),         64'd1);
            checkOutput("err_rdata", 64'(rd_data),     64'(ERRD));
            checkOutput("err_sreq",  64'(slv_req_vld), 64'd0);
            checkOutput("err_idle",  64'(cs_is_idle),  64'd0);
        end else begin
`ifdef SLV_FSM_TIMEOUT_EN
            tmo = (abortAt == 0) && (delay + 1 > TMO);
`else
            tmo = 1'b0;
`endif
            endCycle = (abortAt > 0) ? abortAt : (tmo ? TMO : delay + 1);
            for (int k = 1; k <= endCycle; k++) begin
                @(posedge clk);
                #1;
                mst_sync_reset = (k == abortAt);
                slv_ack_vld    = stray ? (NS'($urandom) & ~sel) : '0;
                if (k == delay + 1) slv_ack_vld = slv_ack_vld | sel;
                mst_req_vld    = stray ? 1'($urandom) : 1'b0;
                if (stray) mst_slv_sel = NS'($urandom);
                driveSlaveData(sel, rdval);
                expAck  = (k == delay + 1) || (tmo && k == endCycle);
                expErr  = tmo && (k == endCycle) && (k != delay + 1);
                expData = !expAck ? '0 : (expErr ? ERRD : rdval);
                #1;
                checkOutput("w_sreq",   64'(slv_req_vld),    64'(sel));
                checkOutput("w_saddr",  64'(slv_addr),       64'(addr));
                checkOutput("w_swdata", 64'(slv_wr_data),    64'(wdata));
                checkOutput("w_swen",   64'(slv_wr_en),      64'(!rd));
                checkOutput("w_sren",   64'(slv_rd_en),      64'(rd));
                checkOutput("w_idle",   64'(cs_is_idle),     64'd0);
                checkOutput("w_ssync",  64'(slv_sync_reset), 64'(k == abortAt));
                checkOutput("w_ack",    64'(ack_vld),        64'(expAck));
                checkOutput("w_err",    64'(err),            64'(expErr));
                checkOutput("w_rdata",  64'(rd_data),        64'(expData));
            end
        end
        idleCycle();
    endtask

    initial begin
        logic [NS-1:0] sel;
        bit            rd;
        int            kind;
        int            delay;
        int            abortAt;
        int            maxAbort;

        testsRun       = 0;
        testsFailed    = 0;
        rst            = 1'b1;
        mst_req_vld    = 1'b0;
        mst_rd_en      = 1'b0;
        mst_wr_en      = 1'b0;
        mst_addr       = '0;
        mst_wr_data    = '0;
        mst_sync_reset = 1'b0;
        mst_slv_sel    = '0;
        slv_ack_vld    = '0;
        slv_rd_data    = '0;

        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("rst");
        rst = 1'b0;

        applyStimulus(4'b0010, 1'b1, 64'h40, 32'h0, 32'h1234, 2, 0, 1'b0);
        applyStimulus(4'b1000, 1'b0, 64'h1_0000_0080, 32'hA5A5, 32'h0, 1, 0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 64'h100, 32'h0, 32'h0, 0, 0, 1'b0);
        applyStimulus(4'b0110, 1'b0, 64'h104, 32'h77, 32'h0, 0, 0, 1'b0);
        applyStimulus(4'b0001, 1'b1, 64'h8, 32'h0, 32'h5555, 0, 0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 64'hC, 32'h0, 32'hBEEF, 4, 2, 1'b0);
        applyStimulus(4'b0001, 1'b0, 64'h10, 32'h1111, 32'h0, 3, 4, 1'b0);
        applyStimulus(4'b0100, 1'b1, 64'h20, 32'h0, 32'hCAFE, 3, 0, 1'b1);
`ifdef SLV_FSM_TIMEOUT_EN
        applyStimulus(4'b0010, 1'b1, 64'h30, 32'h0, 32'h9999, 7, 0, 1'b0);
        applyStimulus(4'b0010, 1'b1, 64'h34, 32'h0, 32'h8888, 4, 0, 1'b0);
`endif

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                sel = '0;
            end else if (kind == 1) begin
                sel = NS'($urandom);
                while ($countones(sel) < 2) sel = NS'($urandom);
            end else begin
                sel = NS'(1) << $urandom_range(0, NS - 1);
            end
            rd       = 1'($urandom);
            delay    = $urandom_range(0, 6);
            maxAbort = (delay + 1 < TMO - 1) ? delay + 1 : TMO - 1;
            abortAt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, maxAbort) : 0;
            applyStimulus(sel, rd, {$urandom, $urandom}, DW'($urandom),
                          rd ? DW'($urandom) : '0, delay, abortAt, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
